// File: rtl/ip_latch_capture.sv
// Captures Z80 I/O writes to IO_ADDRESS into latch_data (clk42m domain).
// Optional readback path is built when LATCH_READBACK_EN is defined.
module ip_latch_capture #(
  parameter logic [7:0]  IO_ADDRESS    = 8'h88,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter logic [7:0]  RESET_VALUE   = 8'h00
) (
  input  logic       clk42m,
  input  logic       reset,
  input  logic       bus_n_iorq,
  input  logic       bus_n_wr,
  input  logic       bus_n_rd,
  input  logic [7:0] bus_address,
  input  logic [7:0] bus_wdata,
  output logic [7:0] latch_data,
  output logic       latch_update
`ifdef LATCH_READBACK_EN
  ,
  output logic [7:0] bus_rdata,
  output logic       bus_rdata_en
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] iorq_q;
  logic [1:0] wr_q;
  logic [7:0] addr_q1;
  logic [7:0] addr_q2;
  logic [7:0] wdata_q1;
  logic [7:0] wdata_q2;
  logic       w_wr_act;
  logic       addr_hit;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       cap;

  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      iorq_q   <= 2'b11;
      wr_q     <= 2'b11;
      addr_q1  <= '0;
      addr_q2  <= '0;
      wdata_q1 <= '0;
      wdata_q2 <= '0;
    end else begin
      iorq_q   <= {iorq_q[0], bus_n_iorq};
      wr_q     <= {wr_q[0], bus_n_wr};
      addr_q1  <= bus_address;
      addr_q2  <= addr_q1;
      wdata_q1 <= bus_wdata;
      wdata_q2 <= wdata_q1;
    end
  end

  assign w_wr_act = !iorq_q[1] && !wr_q[1];
  assign addr_hit = (addr_q2 == IO_ADDRESS);

  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // In ST_RELEASE the counter tracks consecutive idle cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_wr_act) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!w_wr_act) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        cap     = addr_hit;
        cnt_d   = '0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (w_wr_act) begin
          cnt_d = '0;
        end else if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      latch_data   <= RESET_VALUE;
      latch_update <= 1'b0;
    end else begin
      latch_update <= cap;
      if (cap) begin
        latch_data <= wdata_q2;
      end
    end
  end

`ifdef LATCH_READBACK_EN
  logic [1:0] rd_q;
  logic       w_rd_act;

  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      rd_q <= 2'b11;
    end else begin
      rd_q <= {rd_q[0], bus_n_rd};
    end
  end

  assign w_rd_act = !iorq_q[1] && !rd_q[1];

  // A write strobe wins over a simultaneous read.
  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      bus_rdata_en <= 1'b0;
    end else begin
      bus_rdata_en <= w_rd_act && !w_wr_act && addr_hit;
    end
  end

  assign bus_rdata = bus_rdata_en ? latch_data : 8'h00;
`else
  logic rd_unused;
  assign rd_unused = bus_n_rd;
`endif

endmodule
